// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU-side and response signals of the two-requester ALU arbiter.
// slave is the arbiter's view; master is the view of the requesters, ALU and response sink.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH   = 36,
    parameter int ALU_OP_WIDTH = 3
);
    logic                    i_req0_valid, i_req1_valid;
    logic [DATA_WIDTH-1:0]   i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic [ALU_OP_WIDTH-1:0] i_req0_op, i_req1_op;
    logic                    o_req0_ready, o_req1_ready;
    logic [DATA_WIDTH-1:0]   o_alu_a, o_alu_b, i_alu_result;
    logic [ALU_OP_WIDTH-1:0] o_alu_op;
    logic                    i_alu_zero, i_alu_negative;
    logic                    o_rsp_valid, o_rsp_id, o_rsp_zero, o_rsp_negative, i_rsp_ready;
    logic [DATA_WIDTH-1:0]   o_rsp_result;

    modport slave (
        input  i_req0_valid, i_req1_valid, i_req0_a, i_req0_b, i_req1_a, i_req1_b, i_req0_op, i_req1_op,
        output o_req0_ready, o_req1_ready,
        output o_alu_a, o_alu_b, o_alu_op,
        input  i_alu_result, i_alu_zero, i_alu_negative,
        output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_zero, o_rsp_negative,
        input  i_rsp_ready
    );

    modport master (
        output i_req0_valid, i_req1_valid, i_req0_a, i_req0_b, i_req1_a, i_req1_b, i_req0_op, i_req1_op,
        input  o_req0_ready, o_req1_ready,
        input  o_alu_a, o_alu_b, o_alu_op,
        output i_alu_result, i_alu_zero, i_alu_negative,
        input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_zero, o_rsp_negative,
        output i_rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter around a combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIORITY_EN for fixed priority to requester 0; default is round-robin.
module alu_arbiter #(
    parameter int DATA_WIDTH   = 36,
    parameter int ALU_OP_WIDTH = 3
) (
    input logic          i_clk,
    input logic          i_rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   a_q, b_q, res_q;
    logic [ALU_OP_WIDTH-1:0] op_q;
    logic                    id_q, zero_q, neg_q, gnt0, gnt1;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    assign gnt0 = state == IDLE && bus.i_req0_valid;
`else
    // last_q names the requester granted most recently; reset to 1 so requester 0 wins first
    logic last_q;
    assign gnt0 = state == IDLE && bus.i_req0_valid && (!bus.i_req1_valid || last_q);
`endif
    assign gnt1 = state == IDLE && bus.i_req1_valid && !gnt0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            id_q   <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            last_q <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (gnt0 || gnt1) begin
                    a_q   <= gnt1 ? bus.i_req1_a : bus.i_req0_a;
                    b_q   <= gnt1 ? bus.i_req1_b : bus.i_req0_b;
                    op_q  <= gnt1 ? bus.i_req1_op : bus.i_req0_op;
                    id_q  <= gnt1;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
                    last_q <= gnt1;
`endif
                    state <= EXEC;
                end
                EXEC: begin
                    res_q  <= bus.i_alu_result;
                    zero_q <= bus.i_alu_zero;
                    neg_q  <= bus.i_alu_negative;
                    state  <= RESP;
                end
                RESP: if (bus.i_rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_req0_ready   = gnt0;
    assign bus.o_req1_ready   = gnt1;
    assign bus.o_alu_a        = a_q;
    assign bus.o_alu_b        = b_q;
    assign bus.o_alu_op       = op_q;
    assign bus.o_rsp_valid    = state == RESP;
    assign bus.o_rsp_id       = id_q;
    assign bus.o_rsp_result   = res_q;
    assign bus.o_rsp_zero     = zero_q;
    assign bus.o_rsp_negative = neg_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU.
// Honors ALU_ARB_FIXED_PRIORITY_EN for the expected contention order.
module tb_alu_arbiter;
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUBS = 3'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    alu_arbiter_if #(.DATA_WIDTH(36), .ALU_OP_WIDTH(3)) bus ();
    alu_arbiter #(.DATA_WIDTH(36), .ALU_OP_WIDTH(3)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    assign bus.i_alu_result   = bus.o_alu_op == ALU_SUBS ? bus.o_alu_a - bus.o_alu_b : bus.o_alu_a + bus.o_alu_b;
    assign bus.i_alu_zero     = bus.i_alu_result == 36'd0;
    assign bus.i_alu_negative = bus.i_alu_result[35];

    task automatic issue(input int k, input logic [35:0] a, input logic [35:0] b, input logic [2:0] op, output bit to);
        to = 1'b1;
        @(negedge clk);
        if (k == 0) begin
            bus.i_req0_a = a; bus.i_req0_b = b; bus.i_req0_op = op; bus.i_req0_valid = 1'b1;
        end else begin
            bus.i_req1_a = a; bus.i_req1_b = b; bus.i_req1_op = op; bus.i_req1_valid = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            if (k == 0 ? bus.o_req0_ready : bus.o_req1_ready) begin
                @(posedge clk);
                #1;
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (k == 0) bus.i_req0_valid = 1'b0;
        else bus.i_req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit to);
        to = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_rsp_valid) begin
                to = 1'b0;
                return;
            end
        end
    endtask

    task automatic ack();
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (bus.o_rsp_valid !== 1'b0 || bus.o_req0_ready !== 1'b0 || bus.o_req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_handshake: rsp_valid=%b ready0=%b ready1=%b, want 0 0 0", bus.o_rsp_valid, bus.o_req0_ready, bus.o_req1_ready);
        end
        vectors++;
        if (bus.o_alu_a !== 36'd0 || bus.o_alu_b !== 36'd0 || bus.o_alu_op !== 3'd0 || bus.o_rsp_result !== 36'd0) begin
            errors++; $display("FAIL reset_regs: a=%h b=%h op=%h res=%h, want all 0", bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_rsp_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        bit to;
        @(negedge clk);
        bus.i_req0_a = 36'd5; bus.i_req0_b = 36'd3; bus.i_req0_op = ALU_ADD; bus.i_req0_valid = 1'b1;
        #1;
        vectors++;
        if (bus.o_req0_ready !== 1'b1 || bus.o_req1_ready !== 1'b0) begin
            errors++; $display("FAIL add_grant: ready0=%b ready1=%b, want 1 0", bus.o_req0_ready, bus.o_req1_ready);
        end
        @(posedge clk);
        #1;
        bus.i_req0_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_rsp_valid !== 1'b0 || bus.o_alu_a !== 36'd5 || bus.o_alu_b !== 36'd3 || bus.o_req0_ready !== 1'b0) begin
            errors++; $display("FAIL add_exec: rsp_valid=%b a=%0d b=%0d ready0=%b, want 0 5 3 0", bus.o_rsp_valid, bus.o_alu_a, bus.o_alu_b, bus.o_req0_ready);
        end
        @(negedge clk);
        vectors++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 1'b0 || bus.o_rsp_result !== 36'd8 || bus.o_rsp_zero !== 1'b0 || bus.o_rsp_negative !== 1'b0) begin
            errors++; $display("FAIL add_rsp: valid=%b id=%b res=%0d z=%b n=%b, want 1 0 8 0 0", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_result, bus.o_rsp_zero, bus.o_rsp_negative);
        end
        ack();
        vectors++;
        if (bus.o_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL add_idle: rsp_valid=%b, want 0", bus.o_rsp_valid);
        end
        to = 1'b0;
    endtask

    task automatic test_subs();
        bit to;
        issue(1, 36'd4, 36'd4, ALU_SUBS, to);
        wait_rsp(to);
        vectors++;
        if (to || bus.o_rsp_id !== 1'b1 || bus.o_rsp_result !== 36'd0 || bus.o_rsp_zero !== 1'b1 || bus.o_rsp_negative !== 1'b0) begin
            errors++; $display("FAIL subs_zero: timeout=%b id=%b res=%h z=%b n=%b, want 0 1 0 1 0", to, bus.o_rsp_id, bus.o_rsp_result, bus.o_rsp_zero, bus.o_rsp_negative);
        end
        ack();
        issue(1, 36'd3, 36'd4, ALU_SUBS, to);
        wait_rsp(to);
        vectors++;
        if (to || bus.o_rsp_id !== 1'b1 || bus.o_rsp_result !== 36'hFFFFFFFFF || bus.o_rsp_zero !== 1'b0 || bus.o_rsp_negative !== 1'b1) begin
            errors++; $display("FAIL subs_neg: timeout=%b id=%b res=%h z=%b n=%b, want 0 1 fffffffff 0 1", to, bus.o_rsp_id, bus.o_rsp_result, bus.o_rsp_zero, bus.o_rsp_negative);
        end
        ack();
    endtask

    task automatic test_round_robin();
        bit to;
        logic [3:0] exp_order;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        exp_order = 4'b0000;
`else
        exp_order = 4'b1010;
`endif
        @(negedge clk);
        bus.i_req0_a = 36'd10; bus.i_req0_b = 36'd1; bus.i_req0_op = ALU_ADD; bus.i_req0_valid = 1'b1;
        bus.i_req1_a = 36'd20; bus.i_req1_b = 36'd2; bus.i_req1_op = ALU_ADD; bus.i_req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(to);
            vectors++;
            if (to || bus.o_rsp_id !== exp_order[i] || bus.o_rsp_result !== (exp_order[i] ? 36'd22 : 36'd11)) begin
                errors++; $display("FAIL rr_op%0d: timeout=%b id=%b res=%0d, want id %b", i, to, bus.o_rsp_id, bus.o_rsp_result, exp_order[i]);
            end
            ack();
        end
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        bit to;
        issue(0, 36'd7, 36'd2, ALU_SUBS, to);
        wait_rsp(to);
        bus.i_req1_a = 36'd9; bus.i_req1_b = 36'd9; bus.i_req1_op = ALU_ADD; bus.i_req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (to || bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 1'b0 || bus.o_rsp_result !== 36'd5 || bus.o_req0_ready !== 1'b0 || bus.o_req1_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b id=%b res=%0d r0=%b r1=%b, want 1 0 5 0 0", i, bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_result, bus.o_req0_ready, bus.o_req1_ready);
            end
            @(negedge clk);
        end
        ack();
        vectors++;
        if (bus.o_rsp_valid !== 1'b0 || bus.o_req1_ready !== 1'b1) begin
            errors++; $display("FAIL bp_idle: rsp_valid=%b ready1=%b, want 0 1", bus.o_rsp_valid, bus.o_req1_ready);
        end
        bus.i_req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.o_rsp_valid !== 1'b0 || bus.o_alu_a !== 36'd7 || bus.o_req1_ready !== 1'b0) begin
            errors++; $display("FAIL bp_dropped_valid: rsp_valid=%b a=%0d ready1=%b, want 0 7 0", bus.o_rsp_valid, bus.o_alu_a, bus.o_req1_ready);
        end
    endtask

    task automatic test_reset_in_exec();
        bit to;
        bit seen = 1'b0;
        issue(0, 36'd1, 36'd1, ALU_ADD, to);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.o_rsp_valid !== 1'b0 || bus.o_alu_a !== 36'd0) begin
            errors++; $display("FAIL rst_exec_async: rsp_valid=%b a=%0d, want 0 0", bus.o_rsp_valid, bus.o_alu_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen |= bus.o_rsp_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL rst_exec_no_rsp: rsp_valid seen=%b, want 0", seen);
        end
        bus.i_req0_a = 36'd2; bus.i_req0_b = 36'd2; bus.i_req0_op = ALU_ADD; bus.i_req0_valid = 1'b1;
        bus.i_req1_a = 36'd6; bus.i_req1_b = 36'd6; bus.i_req1_op = ALU_ADD; bus.i_req1_valid = 1'b1;
        #1;
        vectors++;
        if (bus.o_req0_ready !== 1'b1 || bus.o_req1_ready !== 1'b0) begin
            errors++; $display("FAIL rst_exec_grant: ready0=%b ready1=%b, want 1 0", bus.o_req0_ready, bus.o_req1_ready);
        end
        @(posedge clk);
        #1;
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        wait_rsp(to);
        vectors++;
        if (to || bus.o_rsp_id !== 1'b0 || bus.o_rsp_result !== 36'd4) begin
            errors++; $display("FAIL rst_exec_rsp: timeout=%b id=%b res=%0d, want 0 0 4", to, bus.o_rsp_id, bus.o_rsp_result);
        end
        ack();
    endtask

    initial begin
        bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0; bus.i_rsp_ready = 1'b0;
        bus.i_req0_a = '0; bus.i_req0_b = '0; bus.i_req0_op = '0;
        bus.i_req1_a = '0; bus.i_req1_b = '0; bus.i_req1_op = '0;
        test_reset();
        test_add();
        test_subs();
        test_round_robin();
        test_back_pressure();
        test_reset_in_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
